toy_bpu_l0btb_nru: RTL
======================

TOY_BPU_L0BTB_NRU -- requirements
Module: toy_bpu_l0btb_nru

Interface
- REQ-001 SHALL have parameter ENTRY_NUM, default 8: entries, power of 2, at least 2.
- REQ-002 SHALL have parameter TAG_WIDTH, default 10: tag is pcgen_pc[TAG_WIDTH:1].
- REQ-003 SHALL have parameter CNT_WIDTH, default 2: per-entry saturating confidence counter width.
- REQ-004 SHALL use ADDR_WIDTH, BPU_OFFSET_WIDTH, ALIGN_WIDTH, FETCH_DATA_WIDTH and bpu_pkg from toy_pack.
- REQ-005 SHALL have ports:
  - clk  in  1  clock, single domain.
  - rst_n  in  1  asynchronous active-low reset.
  - pcgen_vld  in  1  lookup request.
  - pcgen_pc  in  ADDR_WIDTH  lookup PC.
  - pred_vld  out  1  prediction valid.
  - pred_pld  out  bpu_pkg  prediction.
  - upd_vld  in  1  resolved-branch update.
  - upd_pld  in  bpu_pkg  update payload; pred_pc, taken, tgt_pc, offset, is_cext, carry are used.
  - flush_vld  in  1  invalidate all entries.

Function
- REQ-006 SHALL drive pred_vld = pcgen_vld combinationally, with zero-cycle latency.
- REQ-007 SHALL define a hit as entry valid, tag equal and counter MSB = 1; at most one entry matches a tag.
- REQ-008 On a hit, SHALL set pred_pld.taken = 1 and take tgt_pc, offset, is_cext and carry from the entry, using an AND-OR one-hot mux.
- REQ-009 On a miss, SHALL set taken = 0 and tgt_pc = {pcgen_pc[ADDR_WIDTH-1:ALIGN_WIDTH], 0} + FETCH_DATA_WIDTH/8.
- REQ-010 On a miss, SHALL set offset = all-ones - (pcgen_pc[ALIGN_WIDTH-1:0] >> 2), is_cext = 0 and carry = 0.
- REQ-011 SHALL always set pred_pd.pred_pc = pcgen_pc and need_align = 0.
- REQ-012 SHALL register upd_vld/upd_pld into a one-deep update buffer; entry state changes on the cycle after capture.
- REQ-013 Update tag-hit with taken = 1 SHALL increment the counter saturating at 2^CNT_WIDTH-1 and overwrite tgt_pc, offset, is_cext and carry.
- REQ-014 Update tag-hit with taken = 0 SHALL decrement the counter; if the result is 0, the entry SHALL become invalid.
- REQ-015 Update miss with taken = 0 SHALL change nothing.
- REQ-016 Update miss with taken = 1 SHALL allocate the victim with the counter set to 2^(CNT_WIDTH-1) (weakly taken).
- REQ-017 Victim SHALL be the lowest-index invalid entry; if all entries are valid, it SHALL be the lowest-index entry with NRU bit = 0.
- REQ-018 A prediction hit or an update write SHALL set that entry's NRU bit.
- REQ-019 If setting an NRU bit would make all NRU bits 1, all other NRU bits SHALL clear in the same cycle.
- REQ-020 A lookup and a buffered update in the same cycle SHALL both take effect; the lookup sees pre-update array contents unless bypassed per REQ-026.
- REQ-021 flush_vld SHALL clear all valid bits, all NRU bits and the update buffer valid at the next edge; an upd_vld in the same cycle SHALL be dropped.
- REQ-022 Flush SHALL take priority over a pending buffered update in the same cycle.

Reset
- REQ-023 While rst_n = 0, SHALL clear all valid bits, counters, NRU bits, update buffer valid and update buffer payload.
- REQ-024 After reset, pred_pld SHALL be the fall-through value of REQ-009/REQ-010 for the current pcgen_pc.
- REQ-025 Reset asserted mid-update SHALL discard the pending update.

Configuration
- REQ-026 With TOY_BPU_L0BTB_BYPASS_EN defined, a valid buffered update whose tag equals the lookup tag SHALL override the array.
  - Taken: predict taken from the buffer payload.
  - Not taken: predict miss.
- REQ-027 Without TOY_BPU_L0BTB_BYPASS_EN, lookups SHALL see only array contents and no bypass logic SHALL exist.

Verification (ENTRY_NUM = 4, TAG_WIDTH = 8, CNT_WIDTH = 2)
- REQ-028 Reset, then pcgen_pc = 0x1004 -> taken = 0, tgt_pc = 0x1000 + FETCH_DATA_WIDTH/8.
- REQ-029 Update pred_pc 0x1004 taken, tgt 0x2000, then look up 0x1004 two cycles later -> taken = 1, tgt_pc = 0x2000, counter = 2.
- REQ-030 Two not-taken updates for 0x1004 after REQ-029 -> counter 1 then invalid; lookup -> taken = 0.
- REQ-031 Five taken allocations to distinct tags, with lookups hitting entries 0 and 1 -> fifth allocation replaces entry 2.
- REQ-032 With BYPASS_EN, update 0x3008 taken tgt 0x4000, lookup 0x3008 on the next cycle -> taken = 1, tgt_pc = 0x4000.
- REQ-032 Without BYPASS_EN, the same sequence -> taken = 0.
- REQ-033 Flush together with upd_vld for a new tag -> all lookups miss and no allocation occurs.

Source files
------------

// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared BPU widths and the prediction/update payload struct
package toy_pack;

   localparam int ADDR_WIDTH       = 32;
   localparam int ALIGN_WIDTH      = 4;
   localparam int FETCH_DATA_WIDTH = 128;
   localparam int BPU_OFFSET_WIDTH = ALIGN_WIDTH - 2;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]       pred_pc;
      logic                        taken;
      logic [ADDR_WIDTH-1:0]       tgt_pc;
      logic [BPU_OFFSET_WIDTH-1:0] offset;
      logic                        is_cext;
      logic                        carry;
      logic                        need_align;
   } bpu_pkg;

endpackage

// File: rtl/toy_bpu_l0btb_nru.sv
// rtl/toy_bpu_l0btb_nru.sv - zero-latency L0 BTB with NRU replacement and confidence counters
// Optional buffered-update bypass enabled by TOY_BPU_L0BTB_BYPASS_EN.
module toy_bpu_l0btb_nru
   import toy_pack::*;
#(
   parameter int ENTRY_NUM = 8,
   parameter int TAG_WIDTH = 10,
   parameter int CNT_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pcgen_vld,
   input  logic [ADDR_WIDTH-1:0] pcgen_pc,
   output logic                  pred_vld,
   output bpu_pkg                pred_pld,
   input  logic                  upd_vld,
   input  bpu_pkg                upd_pld,
   input  logic                  flush_vld
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [ENTRY_NUM-1:0]        valid_q;
   logic [ENTRY_NUM-1:0]        nru_q;
   logic [TAG_WIDTH-1:0]        tag_q   [ENTRY_NUM];
   logic [CNT_WIDTH-1:0]        cnt_q   [ENTRY_NUM];
   logic [ADDR_WIDTH-1:0]       tgt_q   [ENTRY_NUM];
   logic [BPU_OFFSET_WIDTH-1:0] off_q   [ENTRY_NUM];
   logic [ENTRY_NUM-1:0]        cext_q;
   logic [ENTRY_NUM-1:0]        carry_q;

   logic                        buf_vld_q;
   bpu_pkg                      buf_pld_q;

   logic [TAG_WIDTH-1:0]        look_tag;
   logic [TAG_WIDTH-1:0]        upd_tag;
   logic [ENTRY_NUM-1:0]        hit_vec;
   logic                        arr_hit;
   logic                        use_arr;
   logic [ADDR_WIDTH-1:0]       hit_tgt;
   logic [BPU_OFFSET_WIDTH-1:0] hit_off;
   logic                        hit_cext;
   logic                        hit_carry;

   logic [ENTRY_NUM-1:0]        upd_hit_vec;
   logic                        upd_hit;
   logic [ENTRY_NUM-1:0]        victim_vec;
   logic [ENTRY_NUM-1:0]        wr_vec;
   logic [ENTRY_NUM-1:0]        dec_vec;
   logic [ENTRY_NUM-1:0]        nru_set;
   logic [ENTRY_NUM-1:0]        nru_merged;
   logic [ENTRY_NUM-1:0]        nru_d;
   logic                        unused_bits;

   assign look_tag    = pcgen_pc[TAG_WIDTH:1];
   assign upd_tag     = buf_pld_q.pred_pc[TAG_WIDTH:1];
   assign unused_bits = ^{buf_pld_q.pred_pc, buf_pld_q.need_align};

   // One-hot AND-OR read; tags are unique so at most one hit_vec bit is set.
   always_comb begin
      hit_vec   = '0;
      hit_tgt   = '0;
      hit_off   = '0;
      hit_cext  = 1'b0;
      hit_carry = 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         hit_vec[i] = valid_q[i] & (tag_q[i] == look_tag) & cnt_q[i][CNT_WIDTH-1];
         hit_tgt    = hit_tgt | ({ADDR_WIDTH{hit_vec[i]}} & tgt_q[i]);
         hit_off    = hit_off | ({BPU_OFFSET_WIDTH{hit_vec[i]}} & off_q[i]);
         hit_cext   = hit_cext | (hit_vec[i] & cext_q[i]);
         hit_carry  = hit_carry | (hit_vec[i] & carry_q[i]);
      end
   end

   assign arr_hit = |hit_vec;

`ifdef TOY_BPU_L0BTB_BYPASS_EN
   logic byp_match;
   logic byp_taken;

   // A pending update for the looked-up tag is newer than the array copy.
   assign byp_match = buf_vld_q & (upd_tag == look_tag);
   assign byp_taken = byp_match & buf_pld_q.taken;
   assign use_arr   = arr_hit & ~byp_match;
`else
   assign use_arr   = arr_hit;
`endif

   assign pred_vld = pcgen_vld;

   always_comb begin
      pred_pld            = '0;
      pred_pld.pred_pc    = pcgen_pc;
      pred_pld.need_align = 1'b0;
      pred_pld.taken      = 1'b0;
      pred_pld.tgt_pc     = {pcgen_pc[ADDR_WIDTH-1:ALIGN_WIDTH], {ALIGN_WIDTH{1'b0}}}
                            + ADDR_WIDTH'(FETCH_DATA_WIDTH / 8);
      pred_pld.offset     = {BPU_OFFSET_WIDTH{1'b1}}
                            - BPU_OFFSET_WIDTH'(pcgen_pc[ALIGN_WIDTH-1:0] >> 2);
      pred_pld.is_cext    = 1'b0;
      pred_pld.carry      = 1'b0;
      if (use_arr) begin
         pred_pld.taken   = 1'b1;
         pred_pld.tgt_pc  = hit_tgt;
         pred_pld.offset  = hit_off;
         pred_pld.is_cext = hit_cext;
         pred_pld.carry   = hit_carry;
      end
`ifdef TOY_BPU_L0BTB_BYPASS_EN
      if (byp_taken) begin
         pred_pld.taken   = 1'b1;
         pred_pld.tgt_pc  = buf_pld_q.tgt_pc;
         pred_pld.offset  = buf_pld_q.offset;
         pred_pld.is_cext = buf_pld_q.is_cext;
         pred_pld.carry   = buf_pld_q.carry;
      end
`endif
   end

   // Update match ignores the counter: a weak entry is still the owner of its tag.
   always_comb begin
      upd_hit_vec = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         upd_hit_vec[i] = valid_q[i] & (tag_q[i] == upd_tag);
      end
   end

   assign upd_hit = |upd_hit_vec;

   always_comb begin
      logic found;
      victim_vec = '0;
      found      = 1'b0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (!found && !valid_q[i]) begin
            victim_vec[i] = 1'b1;
            found         = 1'b1;
         end
      end
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (!found && !nru_q[i]) begin
            victim_vec[i] = 1'b1;
            found         = 1'b1;
         end
      end
      if (!found) begin
         victim_vec[0] = 1'b1;
      end
   end

   assign wr_vec  = (buf_vld_q & buf_pld_q.taken)
                    ? (upd_hit ? upd_hit_vec : victim_vec) : '0;
   assign dec_vec = (buf_vld_q & ~buf_pld_q.taken) ? upd_hit_vec : '0;

   // NRU never saturates: when every bit would be set, keep only the new ones.
   assign nru_set    = ((pcgen_vld & use_arr) ? hit_vec : '0) | wr_vec;
   assign nru_merged = nru_q | nru_set;
   assign nru_d      = (&nru_merged) ? nru_set : nru_merged;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= '0;
         nru_q     <= '0;
         cext_q    <= '0;
         carry_q   <= '0;
         buf_vld_q <= 1'b0;
         buf_pld_q <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            tag_q[i] <= '0;
            cnt_q[i] <= '0;
            tgt_q[i] <= '0;
            off_q[i] <= '0;
         end
      end else if (flush_vld) begin
         valid_q   <= '0;
         nru_q     <= '0;
         buf_vld_q <= 1'b0;
      end else begin
         buf_vld_q <= upd_vld;
         if (upd_vld) begin
            buf_pld_q <= upd_pld;
         end
         nru_q <= nru_d;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (wr_vec[i]) begin
               valid_q[i] <= 1'b1;
               tag_q[i]   <= upd_tag;
               tgt_q[i]   <= buf_pld_q.tgt_pc;
               off_q[i]   <= buf_pld_q.offset;
               cext_q[i]  <= buf_pld_q.is_cext;
               carry_q[i] <= buf_pld_q.carry;
               if (!upd_hit) begin
                  cnt_q[i] <= CNT_INIT;
               end else if (cnt_q[i] != CNT_MAX) begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end
            if (dec_vec[i]) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
               if (cnt_q[i] == CNT_ONE) begin
                  valid_q[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule
